ysyx_22050710_wb_retire_queue: RTL and testbench

- Parametrised successor to the single-entry write-back stage.
- Buffers up to DEPTH completed instructions from MS in an in-order retire queue and drains the head into the GPR/CSR register file under write-port backpressure (i_rf_ready).
- Provides NUM_RD GPR bypass lookup ports, plus one CSR lookup port, that search all buffered entries with youngest-match priority.
- Keeps a 64-bit retired-instruction counter.

---
 rtl/ysyx_22050710_wb_retire_queue_pkg.sv | 17 +
 rtl/ysyx_22050710_wb_bypass_match.sv | 27 ++
 rtl/ysyx_22050710_wb_retire_queue.sv | 175 +++++++++++++++++
 tb/tb_ysyx_22050710_wb_retire_queue.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050710_wb_retire_queue_pkg.sv
// ysyx_22050710_wb_retire_queue_pkg: shared widths, entry layout sizing and the index-zero constant
package ysyx_22050710_wb_retire_queue_pkg;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_NUM_RD      = 2;
    localparam int DEF_PC_WD       = 64;
    localparam int DEF_GPR_ADDR_WD = 5;
    localparam int DEF_GPR_WD      = 64;
    localparam int DEF_CSR_ADDR_WD = 12;
    localparam int DEF_CSR_WD      = 64;
    localparam int REG_ZERO        = 0;

    // Width of one packed entry {pc, gpr_wen, rd, gpr_wdata, csr_wen, csr_addr, csr_wdata}
    function automatic int entry_wd(input int pc_wd, input int ga_wd, input int gd_wd,
                                    input int ca_wd, input int cd_wd);
        return pc_wd + 1 + ga_wd + gd_wd + 1 + ca_wd + cd_wd;
    endfunction
endpackage

// File: rtl/ysyx_22050710_wb_bypass_match.sv
// ysyx_22050710_wb_bypass_match: youngest-first keyed search over age-ordered entries (index 0 oldest)
module ysyx_22050710_wb_bypass_match
    import ysyx_22050710_wb_retire_queue_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int KEY_WD  = DEF_GPR_ADDR_WD,
    parameter int DATA_WD = DEF_GPR_WD
) (
    input  logic [DEPTH-1:0]         en_i,
    input  logic [DEPTH*KEY_WD-1:0]  key_i,
    input  logic [DEPTH*DATA_WD-1:0] data_i,
    input  logic [KEY_WD-1:0]        query_i,
    output logic                     hit_o,
    output logic [DATA_WD-1:0]       data_o
);
    // Scan oldest to youngest so a younger match overrides an older one
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (en_i[i] && key_i[i*KEY_WD +: KEY_WD] == query_i) begin
                hit_o  = 1'b1;
                data_o = data_i[i*DATA_WD +: DATA_WD];
            end
        end
    end
endmodule

// File: rtl/ysyx_22050710_wb_retire_queue.sv
// ysyx_22050710_wb_retire_queue: in-order write-back retire queue with GPR/CSR bypass and instret
module ysyx_22050710_wb_retire_queue
    import ysyx_22050710_wb_retire_queue_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int NUM_RD      = DEF_NUM_RD,
    parameter int PC_WD       = DEF_PC_WD,
    parameter int GPR_ADDR_WD = DEF_GPR_ADDR_WD,
    parameter int GPR_WD      = DEF_GPR_WD,
    parameter int CSR_ADDR_WD = DEF_CSR_ADDR_WD,
    parameter int CSR_WD      = DEF_CSR_WD
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    output logic                          o_ws_allowin,
    input  logic                          i_ms_to_ws_valid,
    input  logic [PC_WD-1:0]              i_ms_pc,
    input  logic                          i_ms_gpr_wen,
    input  logic [GPR_ADDR_WD-1:0]        i_ms_rd,
    input  logic [GPR_WD-1:0]             i_ms_gpr_wdata,
    input  logic                          i_ms_csr_wen,
    input  logic [CSR_ADDR_WD-1:0]        i_ms_csr_addr,
    input  logic [CSR_WD-1:0]             i_ms_csr_wdata,
    input  logic                          i_rf_ready,
    output logic                          o_rf_valid,
    output logic                          o_rf_gpr_wen,
    output logic [GPR_ADDR_WD-1:0]        o_rf_gpr_waddr,
    output logic [GPR_WD-1:0]             o_rf_gpr_wdata,
    output logic                          o_rf_csr_wen,
    output logic [CSR_ADDR_WD-1:0]        o_rf_csr_waddr,
    output logic [CSR_WD-1:0]             o_rf_csr_wdata,
    input  logic [NUM_RD*GPR_ADDR_WD-1:0] i_ds_rs_addr,
    output logic [NUM_RD-1:0]             o_ds_rs_hit,
    output logic [NUM_RD*GPR_WD-1:0]      o_ds_rs_data,
    input  logic [CSR_ADDR_WD-1:0]        i_ds_csr_addr,
    output logic                          o_ds_csr_hit,
    output logic [CSR_WD-1:0]             o_ds_csr_data,
    output logic                          o_retire_valid,
    output logic [PC_WD-1:0]              o_retire_pc,
    output logic [63:0]                   o_instret
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = entry_wd(PC_WD, GPR_ADDR_WD, GPR_WD, CSR_ADDR_WD, CSR_WD);

    typedef struct packed {
        logic [PC_WD-1:0]       pc;
        logic                   gpr_wen;
        logic [GPR_ADDR_WD-1:0] rd;
        logic [GPR_WD-1:0]      gpr_wdata;
        logic                   csr_wen;
        logic [CSR_ADDR_WD-1:0] csr_addr;
        logic [CSR_WD-1:0]      csr_wdata;
    } entry_t;

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, age_idx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [63:0]      instret_q, instret_d;
    logic [EW-1:0]    mem_q [DEPTH];
    entry_t           push_ent, head_ent, age_ent;
    logic             not_empty, push, pop;

    logic [DEPTH-1:0]             gpr_en, csr_en;
    logic [DEPTH*GPR_ADDR_WD-1:0] gpr_key;
    logic [DEPTH*GPR_WD-1:0]      gpr_data;
    logic [DEPTH*CSR_ADDR_WD-1:0] csr_key;
    logic [DEPTH*CSR_WD-1:0]      csr_data;

    assign not_empty    = cnt_q != '0;
    assign o_ws_allowin = cnt_q != CW'(DEPTH);
    assign push         = i_ms_to_ws_valid && o_ws_allowin;
    assign pop          = not_empty && i_rf_ready;

    // Incoming entry; a write to x0 is dropped here so neither the RF nor the bypass ever sees it
    always_comb begin
        push_ent           = '0;
        push_ent.pc        = i_ms_pc;
        push_ent.gpr_wen   = i_ms_gpr_wen && (i_ms_rd != GPR_ADDR_WD'(REG_ZERO));
        push_ent.rd        = i_ms_rd;
        push_ent.gpr_wdata = i_ms_gpr_wdata;
        push_ent.csr_wen   = i_ms_csr_wen;
        push_ent.csr_addr  = i_ms_csr_addr;
        push_ent.csr_wdata = i_ms_csr_wdata;
    end

    // Pointer, occupancy, valid-bit and retire-counter next state
    always_comb begin
        head_d    = pop  ? head_q + PW'(1) : head_q;
        tail_d    = push ? tail_q + PW'(1) : tail_q;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        instret_d = instret_q + 64'(pop);
        vld_d     = vld_q;
        if (pop)  vld_d[head_q] = 1'b0;
        if (push) vld_d[tail_q] = 1'b1;
    end

    // Control state with asynchronous clear; queued entries are discarded on reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            vld_q     <= '0;
            instret_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            vld_q     <= vld_d;
            instret_q <= instret_d;
        end
    end

    // Entry payload storage; contents are only observed through the valid bits
    always_ff @(posedge i_clk) begin
        if (push) mem_q[tail_q] <= push_ent;
    end

    assign head_ent       = not_empty ? entry_t'(mem_q[head_q]) : '0;
    assign o_rf_valid     = not_empty;
    assign o_rf_gpr_wen   = pop && head_ent.gpr_wen;
    assign o_rf_gpr_waddr = head_ent.rd;
    assign o_rf_gpr_wdata = head_ent.gpr_wdata;
    assign o_rf_csr_wen   = pop && head_ent.csr_wen;
    assign o_rf_csr_waddr = head_ent.csr_addr;
    assign o_rf_csr_wdata = head_ent.csr_wdata;
    assign o_retire_valid = pop;
    assign o_retire_pc    = head_ent.pc;
    assign o_instret      = instret_q;

    // Rotate storage into age order (slot 0 = head) for the bypass search
    always_comb begin
        age_idx  = '0;
        age_ent  = '0;
        gpr_en   = '0;
        gpr_key  = '0;
        gpr_data = '0;
        csr_en   = '0;
        csr_key  = '0;
        csr_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_idx = head_q + PW'(i);
            age_ent = entry_t'(mem_q[age_idx]);
            gpr_en[i]                          = vld_q[age_idx] && age_ent.gpr_wen;
            gpr_key[i*GPR_ADDR_WD +: GPR_ADDR_WD] = age_ent.rd;
            gpr_data[i*GPR_WD +: GPR_WD]          = age_ent.gpr_wdata;
            csr_en[i]                          = vld_q[age_idx] && age_ent.csr_wen;
            csr_key[i*CSR_ADDR_WD +: CSR_ADDR_WD] = age_ent.csr_addr;
            csr_data[i*CSR_WD +: CSR_WD]          = age_ent.csr_wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rs
        logic [GPR_ADDR_WD-1:0] q;
        logic                   hit;
        logic [GPR_WD-1:0]      data;
        assign q = i_ds_rs_addr[k*GPR_ADDR_WD +: GPR_ADDR_WD];
        ysyx_22050710_wb_bypass_match #(
            .DEPTH(DEPTH), .KEY_WD(GPR_ADDR_WD), .DATA_WD(GPR_WD)
        ) u_match (
            .en_i(gpr_en), .key_i(gpr_key), .data_i(gpr_data),
            .query_i(q), .hit_o(hit), .data_o(data)
        );
        assign o_ds_rs_hit[k]                    = hit && (q != GPR_ADDR_WD'(REG_ZERO));
        assign o_ds_rs_data[k*GPR_WD +: GPR_WD] = o_ds_rs_hit[k] ? data : '0;
    end

    ysyx_22050710_wb_bypass_match #(
        .DEPTH(DEPTH), .KEY_WD(CSR_ADDR_WD), .DATA_WD(CSR_WD)
    ) u_csr_match (
        .en_i(csr_en), .key_i(csr_key), .data_i(csr_data),
        .query_i(i_ds_csr_addr), .hit_o(o_ds_csr_hit), .data_o(o_ds_csr_data)
    );
endmodule

// File: tb/tb_ysyx_22050710_wb_retire_queue.sv
// tb_ysyx_22050710_wb_retire_queue: randomized scoreboard bench against a queue-based reference model
module tb_ysyx_22050710_wb_retire_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic        gwen;
        logic [4:0]  rd;
        logic [63:0] gd;
        logic        cwen;
        logic [11:0] ca;
        logic [63:0] cd;
    } ent_t;

    typedef struct packed {
        logic             allow, rfv, ret;
        logic [63:0]      pc;
        logic             gwen;
        logic [4:0]       ga;
        logic [63:0]      gd;
        logic             cwen;
        logic [11:0]      ca;
        logic [63:0]      cd;
        logic [1:0]       hit;
        logic [1:0][63:0] rsd;
        logic             chit;
        logic [63:0]      cdat;
        logic [63:0]      instret;
    } exp_t;

    logic         i_clk, i_rst_n;
    logic         o_ws_allowin, i_ms_to_ws_valid, i_ms_gpr_wen, i_ms_csr_wen, i_rf_ready;
    logic [63:0]  i_ms_pc, i_ms_gpr_wdata, i_ms_csr_wdata;
    logic [4:0]   i_ms_rd;
    logic [11:0]  i_ms_csr_addr, i_ds_csr_addr;
    logic         o_rf_valid, o_rf_gpr_wen, o_rf_csr_wen, o_ds_csr_hit, o_retire_valid;
    logic [4:0]   o_rf_gpr_waddr;
    logic [63:0]  o_rf_gpr_wdata, o_rf_csr_wdata, o_ds_csr_data, o_retire_pc, o_instret;
    logic [11:0]  o_rf_csr_waddr;
    logic [9:0]   i_ds_rs_addr;
    logic [1:0]   o_ds_rs_hit;
    logic [127:0] o_ds_rs_data;

    ysyx_22050710_wb_retire_queue dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .o_ws_allowin(o_ws_allowin),
        .i_ms_to_ws_valid(i_ms_to_ws_valid), .i_ms_pc(i_ms_pc), .i_ms_gpr_wen(i_ms_gpr_wen),
        .i_ms_rd(i_ms_rd), .i_ms_gpr_wdata(i_ms_gpr_wdata), .i_ms_csr_wen(i_ms_csr_wen),
        .i_ms_csr_addr(i_ms_csr_addr), .i_ms_csr_wdata(i_ms_csr_wdata), .i_rf_ready(i_rf_ready),
        .o_rf_valid(o_rf_valid), .o_rf_gpr_wen(o_rf_gpr_wen), .o_rf_gpr_waddr(o_rf_gpr_waddr),
        .o_rf_gpr_wdata(o_rf_gpr_wdata), .o_rf_csr_wen(o_rf_csr_wen), .o_rf_csr_waddr(o_rf_csr_waddr),
        .o_rf_csr_wdata(o_rf_csr_wdata), .i_ds_rs_addr(i_ds_rs_addr), .o_ds_rs_hit(o_ds_rs_hit),
        .o_ds_rs_data(o_ds_rs_data), .i_ds_csr_addr(i_ds_csr_addr), .o_ds_csr_hit(o_ds_csr_hit),
        .o_ds_csr_data(o_ds_csr_data), .o_retire_valid(o_retire_valid), .o_retire_pc(o_retire_pc),
        .o_instret(o_instret)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          errors = 0;
    ent_t        mq[$];
    exp_t        exp_q[$];
    exp_t        m;
    logic [63:0] minst;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, want);
        end
    endtask

    // Monitor: every cycle with a pending expectation, compare the DUT's outputs mid-cycle
    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            chk("allowin", 64'(o_ws_allowin), 64'(m.allow));
            chk("rf_valid", 64'(o_rf_valid), 64'(m.rfv));
            chk("retire_valid", 64'(o_retire_valid), 64'(m.ret));
            chk("gpr_wen", 64'(o_rf_gpr_wen), 64'(m.gwen));
            chk("gpr_waddr", 64'(o_rf_gpr_waddr), 64'(m.ga));
            chk("gpr_wdata", o_rf_gpr_wdata, m.gd);
            chk("csr_wen", 64'(o_rf_csr_wen), 64'(m.cwen));
            chk("csr_waddr", 64'(o_rf_csr_waddr), 64'(m.ca));
            chk("csr_wdata", o_rf_csr_wdata, m.cd);
            chk("rs0_hit", 64'(o_ds_rs_hit[0]), 64'(m.hit[0]));
            chk("rs1_hit", 64'(o_ds_rs_hit[1]), 64'(m.hit[1]));
            chk("rs0_data", o_ds_rs_data[63:0], m.rsd[0]);
            chk("rs1_data", o_ds_rs_data[127:64], m.rsd[1]);
            chk("csr_hit", 64'(o_ds_csr_hit), 64'(m.chit));
            chk("csr_data", o_ds_csr_data, m.cdat);
            chk("instret", o_instret, m.instret);
            if (m.ret) chk("retire_pc", o_retire_pc, m.pc);
        end
    end

    // Drive one cycle, record what the reference model says the DUT must show, then advance the model
    task automatic step(input logic v, input ent_t ent, input logic rdy,
                        input logic [4:0] q0, input logic [4:0] q1, input logic [11:0] cq);
        exp_t       e;
        ent_t       st;
        logic [4:0] qs [2];
        @(posedge i_clk);
        #1;
        i_ms_to_ws_valid = v;
        i_ms_pc          = ent.pc;
        i_ms_gpr_wen     = ent.gwen;
        i_ms_rd          = ent.rd;
        i_ms_gpr_wdata   = ent.gd;
        i_ms_csr_wen     = ent.cwen;
        i_ms_csr_addr    = ent.ca;
        i_ms_csr_wdata   = ent.cd;
        i_rf_ready       = rdy;
        i_ds_rs_addr     = {q1, q0};
        i_ds_csr_addr    = cq;
        st = ent;
        st.gwen = ent.gwen && (ent.rd != 5'd0);
        e = '0;
        e.allow = mq.size() < DEPTH;
        e.rfv   = mq.size() > 0;
        e.ret   = e.rfv && rdy;
        if (e.rfv) begin
            e.pc   = mq[0].pc;
            e.gwen = rdy && mq[0].gwen;
            e.ga   = mq[0].rd;
            e.gd   = mq[0].gd;
            e.cwen = rdy && mq[0].cwen;
            e.ca   = mq[0].ca;
            e.cd   = mq[0].cd;
        end
        qs[0] = q0;
        qs[1] = q1;
        for (int k = 0; k < 2; k++) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (qs[k] != 5'd0 && mq[i].gwen && mq[i].rd == qs[k]) begin
                    e.hit[k] = 1'b1;
                    e.rsd[k] = mq[i].gd;
                    break;
                end
            end
        end
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].cwen && mq[i].ca == cq) begin
                e.chit = 1'b1;
                e.cdat = mq[i].cd;
                break;
            end
        end
        e.instret = minst;
        exp_q.push_back(e);
        if (e.ret) begin
            void'(mq.pop_front());
            minst++;
        end
        if (v && e.allow) mq.push_back(st);
    endtask

    function automatic ent_t mk(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] gd);
        ent_t r;
        r = '0;
        r.pc = pc;
        r.gwen = 1'b1;
        r.rd = rd;
        r.gd = gd;
        return r;
    endfunction

    function automatic ent_t rnd_ent();
        ent_t r;
        r.pc   = {$urandom, $urandom};
        r.gwen = ($urandom % 4) != 0;
        r.rd   = 5'($urandom_range(0, 7));
        r.gd   = {$urandom, $urandom};
        r.cwen = ($urandom % 2) != 0;
        r.ca   = 12'($urandom_range(0, 3));
        r.cd   = {$urandom, $urandom};
        return r;
    endfunction

    task automatic drain();
        for (int n = 0; n < 4 * DEPTH && mq.size() > 0; n++) step(1'b0, '0, 1'b1, 5'd3, 5'd5, 12'd0);
        chk("drain_empty", 64'(mq.size()), 64'd0);
    endtask

    // Reset-time outputs must be all-zero with allowin high, even while the RF is ready
    task automatic chk_reset(input string tag);
        chk({tag, "_allowin"}, 64'(o_ws_allowin), 64'd1);
        chk({tag, "_rf_valid"}, 64'(o_rf_valid), 64'd0);
        chk({tag, "_gpr_wen"}, 64'(o_rf_gpr_wen), 64'd0);
        chk({tag, "_csr_wen"}, 64'(o_rf_csr_wen), 64'd0);
        chk({tag, "_retire"}, 64'(o_retire_valid), 64'd0);
        chk({tag, "_waddr"}, 64'(o_rf_gpr_waddr), 64'd0);
        chk({tag, "_wdata"}, o_rf_gpr_wdata, 64'd0);
        chk({tag, "_rs_hit"}, 64'(o_ds_rs_hit), 64'd0);
        chk({tag, "_rs_data"}, o_ds_rs_data[63:0], 64'd0);
        chk({tag, "_csr_hit"}, 64'(o_ds_csr_hit), 64'd0);
        chk({tag, "_instret"}, o_instret, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        ent_t e;
        minst = '0;
        i_rst_n = 1'b0;
        i_ms_to_ws_valid = 1'b0;
        i_ms_pc = '0; i_ms_gpr_wen = 1'b0; i_ms_rd = '0; i_ms_gpr_wdata = '0;
        i_ms_csr_wen = 1'b0; i_ms_csr_addr = '0; i_ms_csr_wdata = '0;
        i_rf_ready = 1'b1;
        i_ds_rs_addr = {5'd5, 5'd3};
        i_ds_csr_addr = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk_reset("init");
        i_rst_n = 1'b1;

        step(1'b1, mk(64'h8000_0000, 5'd5, 64'h11), 1'b0, 5'd5, 5'd0, 12'd0);
        step(1'b0, '0, 1'b0, 5'd5, 5'd0, 12'd0);
        step(1'b0, '0, 1'b1, 5'd5, 5'd0, 12'd0);
        step(1'b0, '0, 1'b0, 5'd5, 5'd0, 12'd0);

        for (int i = 0; i < DEPTH; i++) step(1'b1, mk(64'h100 + 64'(4 * i), 5'(i + 1), 64'(i)), 1'b0, 5'd1, 5'd4, 12'd0);
        step(1'b1, mk(64'h200, 5'd7, 64'h77), 1'b1, 5'd7, 5'd2, 12'd0);
        step(1'b0, '0, 1'b0, 5'd7, 5'd2, 12'd0);
        drain();

        step(1'b1, mk(64'h300, 5'd3, 64'hAA), 1'b0, 5'd3, 5'd3, 12'd0);
        step(1'b1, mk(64'h304, 5'd3, 64'hBB), 1'b0, 5'd3, 5'd3, 12'd0);
        step(1'b0, '0, 1'b0, 5'd3, 5'd0, 12'd0);
        drain();

        step(1'b1, mk(64'h400, 5'd0, 64'h55), 1'b0, 5'd0, 5'd0, 12'd0);
        step(1'b0, '0, 1'b1, 5'd0, 5'd0, 12'd0);
        e = mk(64'h404, 5'd0, 64'h0);
        e.gwen = 1'b0; e.cwen = 1'b1; e.ca = 12'd0; e.cd = 64'hC5;
        step(1'b1, e, 1'b0, 5'd0, 5'd0, 12'd0);
        step(1'b0, '0, 1'b1, 5'd0, 5'd0, 12'd0);

        step(1'b1, mk(64'h500, 5'd9, 64'h90), 1'b0, 5'd9, 5'd0, 12'd0);
        for (int i = 1; i <= 10; i++) step(1'b1, mk(64'h500 + 64'(4 * i), 5'd9, 64'(8'h90 + i)), 1'b1, 5'd9, 5'd0, 12'd0);
        drain();

        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, rnd_ent(), ($urandom % 3) != 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom_range(0, 3)));

        for (int i = 0; i < 3; i++) step(1'b1, mk(64'h600 + 64'(4 * i), 5'd6, 64'(i + 1)), 1'b0, 5'd6, 5'd6, 12'd0);
        @(posedge i_clk);
        #1;
        i_ms_to_ws_valid = 1'b0;
        i_rf_ready = 1'b1;
        i_rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        @(negedge i_clk);
        chk("rst_mid_hold_gpr_wen", 64'(o_rf_gpr_wen), 64'd0);
        chk("rst_mid_hold_rf_valid", 64'(o_rf_valid), 64'd0);
        #2;
        i_rst_n = 1'b1;
        mq.delete();
        minst = '0;

        for (int i = 0; i < 60; i++)
            step(($urandom % 2) != 0, rnd_ent(), ($urandom % 2) != 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom_range(0, 3)));
        drain();
        @(negedge i_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
